mem_stage_ctrl: RTL and testbench

//   MEM stage plus MEM/WB pipeline register. It consumes the EX/MEM register outputs
//   (MEM_M, WB_M, ALUOut_M, WriteData_M, WriteReg_M).
//   It runs loads/stores on a req/ack data-memory bus and raises StallM while an access
//   is in flight. It also registers the results for the WB stage.

---
 rtl/mem_stage_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// MEM pipeline stage plus the MEM/WB register. Loads and stores go out on a
// req/ack data-memory bus. StallM holds the front of the pipeline while an
// access is outstanding. Misaligned and timed-out accesses are dropped: they
// become a WB bubble and raise a one-cycle mem_err pulse.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | no access outstanding; decode the instruction now in MEM
//   WAIT   | dmem_req asserted; waiting for dmem_ack or the timeout
module mem_stage_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  MEM_M,
    input  logic [1:0]  WB_M,
    input  logic [31:0] ALUOut_M,
    input  logic [31:0] WriteData_M,
    input  logic [4:0]  WriteReg_M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic        mem_err,
    output logic [1:0]  WB_W,
    output logic [31:0] ReadData_W,
    output logic [31:0] ALUOut_W,
    output logic [4:0]  WriteReg_W
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;

    logic mem_op;
    logic misaligned;
    logic stall_raw;
    logic start_acc;
    logic ack_done;
    logic timed_out;
    logic misalign_err;
    logic err_now;

    assign mem_op     = |MEM_M;
    assign misaligned = mem_op && (ALUOut_M[1:0] != 2'b00);

    // State register; reset drops any access in flight, so a late ack
    // lands in IDLE and is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-cycle strobes for the datapath below.
    always_comb begin
        state_nxt    = state;
        stall_raw    = 1'b0;
        start_acc    = 1'b0;
        ack_done     = 1'b0;
        timed_out    = 1'b0;
        misalign_err = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_op && !misaligned) begin
                    stall_raw = 1'b1;
                    start_acc = 1'b1;
                    state_nxt = S_WAIT;
                end else if (misaligned) begin
                    misalign_err = 1'b1;
                end
            end
            S_WAIT: begin
                if (dmem_ack) begin
                    ack_done  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    timed_out = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    stall_raw = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Stall is forced low during reset so the pipeline is not frozen by a
    // memory op sitting in MEM while rst_n is asserted.
    assign StallM  = stall_raw && rst_n;
    assign err_now = misalign_err || timed_out;

    // Cycles spent in WAIT without an ack; cleared on every new access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (start_acc) begin
            wait_cnt <= '0;
        end else if (state == S_WAIT && stall_raw) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Bus request; rises on access start, falls on ack or timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req <= 1'b0;
        end else if (start_acc) begin
            dmem_req <= 1'b1;
        end else if (ack_done || timed_out) begin
            dmem_req <= 1'b0;
        end
    end

    // Address/data/direction are captured once at start and held stable for
    // the whole access. Write takes priority when both MEM bits are set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else if (start_acc) begin
            dmem_we    <= MEM_M[0];
            dmem_addr  <= {ALUOut_M[31:2], 2'b00};
            dmem_wdata <= WriteData_M;
        end
    end

    // Error pulse, one cycle wide, for misaligned or timed-out accesses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_err <= 1'b0;
        end else begin
            mem_err <= err_now;
        end
    end

    // MEM/WB control: bubble while stalled or on error, otherwise pass on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WB_W       <= 2'b00;
            ALUOut_W   <= '0;
            WriteReg_W <= '0;
        end else if (stall_raw || err_now) begin
            WB_W <= 2'b00;
        end else begin
            WB_W       <= WB_M;
            ALUOut_W   <= ALUOut_M;
            WriteReg_W <= WriteReg_M;
        end
    end

    // Load data is only updated by a completed read; stores leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ReadData_W <= '0;
        end else if (ack_done && !dmem_we) begin
            ReadData_W <= dmem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: no-op, load, store, misaligned,
// timeout and reset-during-access sequences with hand-computed results.
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst_n;
    logic [1:0]  MEM_M;
    logic [1:0]  WB_M;
    logic [31:0] ALUOut_M;
    logic [31:0] WriteData_M;
    logic [4:0]  WriteReg_M;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        StallM;
    logic        mem_err;
    logic [1:0]  WB_W;
    logic [31:0] ReadData_W;
    logic [31:0] ALUOut_W;
    logic [4:0]  WriteReg_W;

    int errors = 0;
    int checks = 0;

    mem_stage_ctrl #(.TIMEOUT(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MEM_M       (MEM_M),
        .WB_M        (WB_M),
        .ALUOut_M    (ALUOut_M),
        .WriteData_M (WriteData_M),
        .WriteReg_M  (WriteReg_M),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_ack    (dmem_ack),
        .dmem_rdata  (dmem_rdata),
        .StallM      (StallM),
        .mem_err     (mem_err),
        .WB_W        (WB_W),
        .ReadData_W  (ReadData_W),
        .ALUOut_W    (ALUOut_W),
        .WriteReg_W  (WriteReg_W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [1:0] mem, input logic [1:0] wb,
                             input logic [31:0] alu, input logic [31:0] wd,
                             input logic [4:0] wr);
        MEM_M       = mem;
        WB_M        = wb;
        ALUOut_M    = alu;
        WriteData_M = wd;
        WriteReg_M  = wr;
    endtask

    initial begin
        int hi;
        rst_n      = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        set_instr(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        #3;
        chk("rst_req",   {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, StallM},   32'd0);
        chk("rst_err",   {31'd0, mem_err},  32'd0);
        chk("rst_wbw",   {30'd0, WB_W},     32'd0);
        chk("rst_rdata", ReadData_W,        32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // 1: no-op ALU instruction
        set_instr(2'b00, 2'b10, 32'h1234, 32'h0, 5'd5);
        #1 chk("t1_stall", {31'd0, StallM}, 32'd0);
        tick();
        chk("t1_wbw",   {30'd0, WB_W},      32'd2);
        chk("t1_alu",   ALUOut_W,           32'h1234);
        chk("t1_wreg",  {27'd0, WriteReg_W}, 32'd5);
        chk("t1_req",   {31'd0, dmem_req},  32'd0);

        // 2: load, ack arrives one cycle after req rises
        set_instr(2'b10, 2'b11, 32'h100, 32'hFFFF_0000, 5'd7);
        #1 chk("t2_stall0", {31'd0, StallM}, 32'd1);
        tick();
        chk("t2_req",    {31'd0, dmem_req}, 32'd1);
        chk("t2_we",     {31'd0, dmem_we},  32'd0);
        chk("t2_addr",   dmem_addr,         32'h100);
        chk("t2_bubble", {30'd0, WB_W},     32'd0);
        chk("t2_stall1", {31'd0, StallM},   32'd1);
        tick();
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #1 chk("t2_stall2", {31'd0, StallM}, 32'd0);
        tick();
        dmem_ack = 1'b0;
        set_instr(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        chk("t2_req_lo", {31'd0, dmem_req},  32'd0);
        chk("t2_rdata",  ReadData_W,         32'hDEAD_BEEF);
        chk("t2_wbw",    {30'd0, WB_W},      32'd3);
        chk("t2_alu",    ALUOut_W,           32'h100);
        chk("t2_wreg",   {27'd0, WriteReg_W}, 32'd7);
        chk("t2_err",    {31'd0, mem_err},   32'd0);

        // 3: store, ack on first WAIT cycle
        set_instr(2'b01, 2'b00, 32'h20, 32'hA5A5_A5A5, 5'd0);
        #1 chk("t3_stall0", {31'd0, StallM}, 32'd1);
        tick();
        chk("t3_req",   {31'd0, dmem_req}, 32'd1);
        chk("t3_we",    {31'd0, dmem_we},  32'd1);
        chk("t3_addr",  dmem_addr,         32'h20);
        chk("t3_wdata", dmem_wdata,        32'hA5A5_A5A5);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h1111_1111;
        #1 chk("t3_stall1", {31'd0, StallM}, 32'd0);
        tick();
        dmem_ack = 1'b0;
        set_instr(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        chk("t3_req_lo", {31'd0, dmem_req}, 32'd0);
        chk("t3_rdata",  ReadData_W,        32'hDEAD_BEEF);

        // 4: misaligned load
        set_instr(2'b10, 2'b11, 32'h102, 32'h0, 5'd9);
        #1 chk("t4_stall", {31'd0, StallM}, 32'd0);
        tick();
        chk("t4_req", {31'd0, dmem_req}, 32'd0);
        chk("t4_err", {31'd0, mem_err},  32'd1);
        chk("t4_wbw", {30'd0, WB_W},     32'd0);
        set_instr(2'b00, 2'b10, 32'h44, 32'h0, 5'd3);
        tick();
        chk("t4_err_lo", {31'd0, mem_err}, 32'd0);
        chk("t4_wbw2",   {30'd0, WB_W},    32'd2);

        // 5: load with no ack -> timeout after 16 request cycles
        set_instr(2'b10, 2'b11, 32'h200, 32'h0, 5'd4);
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (dmem_req) hi++;
            if (mem_err) break;
        end
        chk("t5_hi",  hi,                 32'd16);
        chk("t5_err", {31'd0, mem_err},   32'd1);
        chk("t5_req", {31'd0, dmem_req},  32'd0);
        chk("t5_wbw", {30'd0, WB_W},      32'd0);
        set_instr(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        #1 chk("t5_stall", {31'd0, StallM}, 32'd0);
        tick();
        chk("t5_err_lo", {31'd0, mem_err}, 32'd0);

        // 6: reset while waiting, late ack ignored, next load normal
        set_instr(2'b10, 2'b11, 32'h300, 32'h0, 5'd6);
        tick();
        chk("t6_req", {31'd0, dmem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req",   {31'd0, dmem_req}, 32'd0);
        chk("t6_rst_stall", {31'd0, StallM},   32'd0);
        chk("t6_rst_wbw",   {30'd0, WB_W},     32'd0);
        tick();
        rst_n = 1'b1;
        set_instr(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h0000_0BAD;
        tick();
        dmem_ack = 1'b0;
        chk("t6_late_req",   {31'd0, dmem_req}, 32'd0);
        chk("t6_late_rdata", ReadData_W,        32'd0);
        chk("t6_late_err",   {31'd0, mem_err},  32'd0);
        set_instr(2'b10, 2'b10, 32'h400, 32'h0, 5'd8);
        tick();
        chk("t6_req2", {31'd0, dmem_req}, 32'd1);
        chk("t6_addr", dmem_addr,         32'h400);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_ack = 1'b0;
        set_instr(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
        chk("t6_rdata", ReadData_W,          32'hCAFE_F00D);
        chk("t6_wbw",   {30'd0, WB_W},       32'd2);
        chk("t6_wreg",  {27'd0, WriteReg_W}, 32'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
